// File: rtl/load_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_buffer
//  Description : In-order load/store queue between the RS/ROB and the memory
//                controller. Loads issue from the head at once; stores wait
//                for their ROB commit. A flush keeps only committed stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_buffer #(
   parameter int ROB_WIDTH = 4,
   parameter int LSB_WIDTH = 3,
   parameter int LSB_SIZE  = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 from_rs,
   input  logic [ROB_WIDTH-1:0] from_rs_tag,
   input  logic                 from_rs_store,
   input  logic [1:0]           from_rs_width,
   input  logic                 from_rs_signed,
   input  logic [31:0]          from_rs_addr,
   input  logic [31:0]          from_rs_sdata,
   input  logic                 from_rob,
   input  logic [ROB_WIDTH-1:0] from_rob_tag,
   output logic                 to_rs_full,
   output logic                 to_rob,
   output logic [ROB_WIDTH-1:0] to_rob_tag,
   output logic [31:0]          to_rob_wdata,
   output logic                 to_mem_req,
   output logic                 to_mem_we,
   output logic [31:0]          to_mem_addr,
   output logic [31:0]          to_mem_wdata,
   output logic [1:0]           to_mem_width,
   input  logic                 from_mem_done,
   input  logic [31:0]          from_mem_rdata
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                 r_state;
   logic                   r_kill;      // in-flight load was flushed; drop its result
   logic [LSB_WIDTH-1:0]   r_head;
   logic [LSB_WIDTH-1:0]   r_tail;
   logic [LSB_WIDTH:0]     r_count;
   logic [LSB_SIZE-1:0]    r_valid;
   logic [LSB_SIZE-1:0]    r_commit;
   logic [LSB_SIZE-1:0]    r_store;
   logic [LSB_SIZE-1:0]    r_signed;
   logic [ROB_WIDTH-1:0]   r_tag   [LSB_SIZE];
   logic [1:0]             r_width [LSB_SIZE];
   logic [31:0]            r_addr  [LSB_SIZE];
   logic [31:0]            r_sdata [LSB_SIZE];

   logic [LSB_SIZE-1:0]    w_commit;
   logic [LSB_SIZE-1:0]    w_valid_eff;
   logic [LSB_SIZE-1:0]    w_valid_n;
   logic [LSB_SIZE-1:0]    w_commit_n;
   logic [LSB_SIZE-1:0]    w_keep_mask;
   logic [LSB_WIDTH:0]     w_keep_cnt;
   logic [LSB_WIDTH:0]     w_count_n;
   logic [LSB_WIDTH-1:0]   w_head_n;
   logic                   w_head_valid;
   logic                   w_head_store;
   logic                   w_issue;
   logic                   w_pop;
   logic                   w_kill_now;
   logic                   w_adv;
   logic                   w_alloc;
   logic [31:0]            w_ext;

   assign w_head_valid = r_valid[r_head];
   assign w_head_store = r_store[r_head];
   assign w_issue      = (r_state == ST_IDLE) & ~clear & w_head_valid &
                         (~w_head_store | w_commit[r_head]);
   assign w_pop        = (r_state == ST_BUSY) & from_mem_done & ~r_kill;
   // A flushed in-flight load leaves the queue immediately; its done comes later.
   assign w_kill_now   = clear & (r_state == ST_BUSY) & ~from_mem_done & ~r_kill & ~w_head_store;
   assign w_adv        = w_pop | w_kill_now;
   assign w_head_n     = r_head + LSB_WIDTH'(w_adv);
   assign w_alloc      = from_rs & ~clear & (r_count != (LSB_WIDTH+1)'(LSB_SIZE));

   // CAM search: commit view including this cycle's ROB commit pulse
   always_comb begin
      for (int i = 0; i < LSB_SIZE; i++) begin
         w_commit[i] = r_commit[i] |
                       (from_rob & r_valid[i] & r_store[i] & (r_tag[i] == from_rob_tag));
      end
   end

   // Valid/commit vectors after this cycle's pop and allocation
   always_comb begin
      w_valid_eff = r_valid;
      if (w_adv) begin
         w_valid_eff[r_head] = 1'b0;
      end
      w_valid_n  = w_valid_eff;
      w_commit_n = w_commit & w_valid_eff;
      if (w_alloc) begin
         w_valid_n[r_tail]  = 1'b1;
         w_commit_n[r_tail] = 1'b0;
      end
   end

   // Flush survivors: run of committed stores starting at the new head
   always_comb begin
      logic                 w_run;
      logic [LSB_WIDTH-1:0] w_idx;
      w_keep_mask = '0;
      w_keep_cnt  = '0;
      w_run       = 1'b1;
      w_idx       = w_head_n;
      for (int i = 0; i < LSB_SIZE; i++) begin
         w_run = w_run & w_valid_eff[w_idx] & r_store[w_idx] & w_commit[w_idx];
         if (w_run) begin
            w_keep_mask[w_idx] = 1'b1;
            w_keep_cnt         = w_keep_cnt + 1'b1;
         end
         w_idx = w_idx + 1'b1;
      end
   end

   // Next occupancy, used for both the count register and the full flag
   always_comb begin
      if (clear) begin
         w_count_n = w_keep_cnt;
      end else begin
         w_count_n = r_count + {{LSB_WIDTH{1'b0}}, w_alloc} - {{LSB_WIDTH{1'b0}}, w_pop};
      end
   end

   // Load result extension from the head entry's width/sign
   always_comb begin
      case (r_width[r_head])
         2'd0:    w_ext = {{24{r_signed[r_head] & from_mem_rdata[7]}},  from_mem_rdata[7:0]};
         2'd1:    w_ext = {{16{r_signed[r_head] & from_mem_rdata[15]}}, from_mem_rdata[15:0]};
         default: w_ext = from_mem_rdata;
      endcase
   end

   // Queue pointers, occupancy and per-entry valid/commit state
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_valid    <= '0;
         r_commit   <= '0;
         to_rs_full <= 1'b0;
      end else if (rdy_in) begin
         r_head     <= w_head_n;
         r_count    <= w_count_n;
         to_rs_full <= (w_count_n >= (LSB_WIDTH+1)'(LSB_SIZE-1));
         if (clear) begin
            r_tail   <= w_head_n + w_keep_cnt[LSB_WIDTH-1:0];
            r_valid  <= w_keep_mask;
            r_commit <= w_keep_mask;
         end else begin
            r_tail   <= r_tail + LSB_WIDTH'(w_alloc);
            r_valid  <= w_valid_n;
            r_commit <= w_commit_n;
         end
      end
   end

   // Entry payload capture at the tail on allocation
   always_ff @(posedge clk_in) begin
      if (rdy_in && w_alloc) begin
         r_tag[r_tail]    <= from_rs_tag;
         r_store[r_tail]  <= from_rs_store;
         r_width[r_tail]  <= from_rs_width;
         r_signed[r_tail] <= from_rs_signed;
         r_addr[r_tail]   <= from_rs_addr;
         r_sdata[r_tail]  <= from_rs_sdata;
      end
   end

   // Issue/complete FSM with registered memory and ROB outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state      <= ST_IDLE;
         r_kill       <= 1'b0;
         to_mem_req   <= 1'b0;
         to_mem_we    <= 1'b0;
         to_mem_addr  <= '0;
         to_mem_wdata <= '0;
         to_mem_width <= '0;
         to_rob       <= 1'b0;
         to_rob_tag   <= '0;
         to_rob_wdata <= '0;
      end else if (rdy_in) begin
         to_mem_req <= 1'b0;
         to_rob     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state      <= ST_BUSY;
                  to_mem_req   <= 1'b1;
                  to_mem_we    <= w_head_store;
                  to_mem_addr  <= r_addr[r_head];
                  to_mem_wdata <= r_sdata[r_head];
                  to_mem_width <= r_width[r_head];
               end
            end
            ST_BUSY: begin
               if (from_mem_done) begin
                  r_state <= ST_IDLE;
                  r_kill  <= 1'b0;
                  if (!r_kill && !w_head_store) begin
                     to_rob       <= 1'b1;
                     to_rob_tag   <= r_tag[r_head];
                     to_rob_wdata <= w_ext;
                  end
               end else if (w_kill_now) begin
                  r_kill <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_buffer
//  Description : Self-checking bench for load_store_buffer with a queue model
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        clear = 1'b0;
   logic        from_rs = 1'b0;
   logic [3:0]  from_rs_tag = '0;
   logic        from_rs_store = 1'b0;
   logic [1:0]  from_rs_width = '0;
   logic        from_rs_signed = 1'b0;
   logic [31:0] from_rs_addr = '0;
   logic [31:0] from_rs_sdata = '0;
   logic        from_rob = 1'b0;
   logic [3:0]  from_rob_tag = '0;
   logic        to_rs_full, to_rob, to_mem_req, to_mem_we;
   logic [3:0]  to_rob_tag;
   logic [31:0] to_rob_wdata, to_mem_addr, to_mem_wdata;
   logic [1:0]  to_mem_width;
   logic        from_mem_done = 1'b0;
   logic [31:0] from_mem_rdata = '0;

   always #5 clk = ~clk;

   load_store_buffer #(.ROB_WIDTH(4), .LSB_WIDTH(3), .LSB_SIZE(8)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
      .from_rs(from_rs), .from_rs_tag(from_rs_tag), .from_rs_store(from_rs_store),
      .from_rs_width(from_rs_width), .from_rs_signed(from_rs_signed),
      .from_rs_addr(from_rs_addr), .from_rs_sdata(from_rs_sdata),
      .from_rob(from_rob), .from_rob_tag(from_rob_tag),
      .to_rs_full(to_rs_full), .to_rob(to_rob), .to_rob_tag(to_rob_tag),
      .to_rob_wdata(to_rob_wdata), .to_mem_req(to_mem_req), .to_mem_we(to_mem_we),
      .to_mem_addr(to_mem_addr), .to_mem_wdata(to_mem_wdata), .to_mem_width(to_mem_width),
      .from_mem_done(from_mem_done), .from_mem_rdata(from_mem_rdata)
   );

   typedef struct packed {
      logic [3:0]  tag;
      logic        st;
      logic [1:0]  w;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] sd;
      logic        cm;
   } op_t;

   int errors = 0;
   int checks = 0;
   int n_req = 0;
   int n_rob = 0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ext(op_t o, logic [31:0] d);
      case (o.w)
         2'd0:    return o.sg ? {{24{d[7]}}, d[7:0]}   : {24'h0, d[7:0]};
         2'd1:    return o.sg ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   // ---------------- behavioural queue model ----------------
   op_t  q[$];
   bit   m_busy = 0, m_killed = 0;
   bit   e_req = 0, e_rob = 0, e_full = 0;
   op_t  e_op;
   logic [3:0]  e_tag = '0;
   logic [31:0] e_data = '0;

   always @(posedge clk) begin
      int n;
      op_t o;
      e_req = 0;
      e_rob = 0;
      if (rst) begin
         q.delete();
         m_busy = 0;
         m_killed = 0;
         e_full = 0;
      end else begin
         if (from_rob)
            foreach (q[i]) if (q[i].st && q[i].tag == from_rob_tag) q[i].cm = 1'b1;
         if (m_busy) begin
            if (from_mem_done) begin
               if (!m_killed) begin
                  if (!q[0].st) begin
                     e_rob = 1;
                     e_tag = q[0].tag;
                     e_data = ext(q[0], from_mem_rdata);
                  end
                  void'(q.pop_front());
               end
               m_busy = 0;
               m_killed = 0;
            end else if (clear && !m_killed && !q[0].st) begin
               m_killed = 1;
               void'(q.pop_front());
            end
         end else if (!clear && q.size() > 0 && (!q[0].st || q[0].cm)) begin
            e_req = 1;
            e_op = q[0];
            m_busy = 1;
         end
         if (clear) begin
            n = 0;
            while (n < q.size() && q[n].st && q[n].cm) n++;
            while (q.size() > n) void'(q.pop_back());
         end else if (from_rs) begin
            if (q.size() == 8) begin
               checks++;
               errors++;
               $display("FAIL alloc_overflow: allocation with 8 entries in use");
            end else begin
               o = '{tag: from_rs_tag, st: from_rs_store, w: from_rs_width, sg: from_rs_signed,
                     addr: from_rs_addr, sd: from_rs_sdata, cm: 1'b0};
               q.push_back(o);
            end
         end
         e_full = (q.size() >= 7);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_ctrl", {to_mem_req, to_rob, to_rs_full, to_mem_we}, 0);
      end else begin
         chk("mem_req", to_mem_req, e_req);
         if (e_req && to_mem_req) begin
            chk("mem_we", to_mem_we, e_op.st);
            chk("mem_addr", to_mem_addr, e_op.addr);
            chk("mem_width", to_mem_width, e_op.w);
            if (e_op.st) chk("mem_wdata", to_mem_wdata, e_op.sd);
         end
         chk("rob_valid", to_rob, e_rob);
         if (e_rob && to_rob) begin
            chk("rob_tag", to_rob_tag, e_tag);
            chk("rob_wdata", to_rob_wdata, e_data);
         end
         chk("rs_full", to_rs_full, e_full);
      end
      if (to_mem_req) n_req++;
      if (to_rob) n_rob++;
   end

   // ---------------- memory responder ----------------
   int          mem_lat = 3;
   logic [31:0] mem_rdata = '0;
   int          mcnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         mcnt = 0;
         from_mem_done = 1'b0;
      end else begin
         from_mem_done = 1'b0;
         if (to_mem_req) mcnt = mem_lat;
         else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               from_mem_done = 1'b1;
               from_mem_rdata = mem_rdata;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      from_rs = 1'b0;
      from_rob = 1'b0;
      clear = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic alloc(logic [3:0] tag, logic st, logic [1:0] w, logic sg,
                        logic [31:0] addr, logic [31:0] sd);
      tick();
      from_rs = 1'b1; from_rs_tag = tag; from_rs_store = st; from_rs_width = w;
      from_rs_signed = sg; from_rs_addr = addr; from_rs_sdata = sd;
   endtask

   task automatic commit(logic [3:0] tag);
      tick();
      from_rob = 1'b1;
      from_rob_tag = tag;
   endtask

   task automatic do_clear();
      tick();
      clear = 1'b1;
   endtask

   task automatic wait_req(string name);
      int k = 0;
      do begin tick(); #1; k++; end while (!to_mem_req && k < 60);
      chk(name, to_mem_req, 1'b1);
   endtask

   task automatic wait_rob(string name, logic [3:0] tag, logic [31:0] data);
      int k = 0;
      do begin tick(); #1; k++; end while (!to_rob && k < 60);
      chk({name, "_seen"}, to_rob, 1'b1);
      chk({name, "_tag"}, to_rob_tag, tag);
      chk({name, "_data"}, to_rob_wdata, data);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int r0, q0;
      idle(2);
      #1 chk("reset_outputs", {to_mem_req, to_mem_we, to_rob, to_rs_full, to_mem_width,
                               to_rob_tag, to_mem_addr, to_mem_wdata, to_rob_wdata}, 0);
      tick();
      rst = 1'b0;
      idle(2);

      // 1: word load
      mem_lat = 3; mem_rdata = 32'hDEADBEEF;
      alloc(4'd1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      wait_req("t1_req");
      chk("t1_req_fields", {to_mem_we, to_mem_addr}, {1'b0, 32'h100});
      wait_rob("t1_rob", 4'd1, 32'hDEADBEEF);

      // 2: sub-word extension
      mem_rdata = 32'h00000080;
      alloc(4'd2, 1'b0, 2'd0, 1'b1, 32'h104, 32'h0);
      wait_rob("t2_lb", 4'd2, 32'hFFFFFF80);
      alloc(4'd3, 1'b0, 2'd0, 1'b0, 32'h104, 32'h0);
      wait_rob("t2_lbu", 4'd3, 32'h00000080);
      mem_rdata = 32'h00008001;
      alloc(4'd4, 1'b0, 2'd1, 1'b1, 32'h106, 32'h0);
      wait_rob("t2_lh", 4'd4, 32'hFFFF8001);

      // 3: store waits for commit, load behind waits for store
      mem_rdata = 32'h0BADF00D;
      alloc(4'd5, 1'b1, 2'd2, 1'b0, 32'h200, 32'h12345678);
      alloc(4'd6, 1'b0, 2'd2, 1'b0, 32'h204, 32'h0);
      q0 = n_req;
      idle(10);
      #1 chk("t3_no_req_uncommitted", n_req - q0, 0);
      commit(4'd5);
      tick();
      #1 chk("t3_commit_issue", {to_mem_req, to_mem_we, to_mem_wdata}, {2'b11, 32'h12345678});
      wait_rob("t3_load_after_store", 4'd6, 32'h0BADF00D);

      // 4: full flag with uncommitted store at head
      mem_rdata = 32'h00000011;
      r0 = n_rob;
      alloc(4'd7, 1'b1, 2'd2, 1'b0, 32'h300, 32'hA5A5A5A5);
      for (int i = 0; i < 5; i++) alloc(4'(8 + i), 1'b0, 2'd2, 1'b0, 32'h304 + 32'(4 * i), 32'h0);
      tick();
      #1 chk("t4_not_full_at_6", to_rs_full, 1'b0);
      alloc(4'd13, 1'b0, 2'd2, 1'b0, 32'h320, 32'h0);
      tick();
      #1 chk("t4_full_at_7", to_rs_full, 1'b1);
      commit(4'd7);
      idle(6);
      #1 chk("t4_full_released", to_rs_full, 1'b0);
      idle(45);
      #1 chk("t4_six_load_results", n_rob - r0, 6);

      // 5: flush keeps two committed stores, drops speculative ops
      mem_lat = 6;
      r0 = n_rob; q0 = n_req;
      alloc(4'd1, 1'b1, 2'd2, 1'b0, 32'h400, 32'hAAAA5555);
      alloc(4'd2, 1'b1, 2'd0, 1'b0, 32'h404, 32'h00000011);
      alloc(4'd3, 1'b0, 2'd2, 1'b0, 32'h408, 32'h0);
      alloc(4'd4, 1'b1, 2'd1, 1'b0, 32'h40C, 32'h00002222);
      alloc(4'd5, 1'b0, 2'd2, 1'b0, 32'h410, 32'h0);
      commit(4'd1);
      commit(4'd2);
      do_clear();
      idle(30);
      #1 chk("t5_two_store_reqs", n_req - q0, 2);
      chk("t5_no_rob", n_rob - r0, 0);

      // 6: flushed in-flight load, then normal load
      mem_lat = 4;
      alloc(4'd6, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
      wait_req("t6_req");
      r0 = n_rob;
      do_clear();
      idle(10);
      #1 chk("t6_killed_no_rob", n_rob - r0, 0);
      mem_rdata = 32'hCAFEF00D;
      alloc(4'd7, 1'b0, 2'd2, 1'b0, 32'h504, 32'h0);
      wait_rob("t6_after_flush", 4'd7, 32'hCAFEF00D);

      // 6b: asynchronous reset while BUSY
      mem_lat = 6;
      alloc(4'd8, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
      wait_req("t6b_req");
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("t6b_async_reset", {to_mem_req, to_mem_we, to_rob, to_rs_full, to_mem_width,
                                 to_rob_tag, to_mem_addr, to_mem_wdata, to_rob_wdata}, 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      mem_lat = 2; mem_rdata = 32'h13572468;
      alloc(4'd9, 1'b0, 2'd2, 1'b0, 32'h700, 32'h0);
      wait_rob("t6b_after_reset", 4'd9, 32'h13572468);
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
